// File: rtl/prop_plug_host_if.sv
// rtl/prop_plug_host_if.sv - Byte-level TX/RX handshake between a loader engine and prop_plug_host
interface prop_plug_host_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output rx_err
    );
endinterface

// File: rtl/prop_plug_host.sv
// rtl/prop_plug_host.sv - Prop Plug host: target reset/boot sequencer, TX FIFO and 8N1 UART
// Optional PROPPLUG_LOOPBACK_EN adds i_loopback, feeding the receiver from the internal txd.
module prop_plug_host #(
    parameter int BAUD_DIV         = 694,
    parameter int RESET_CYCLES     = 8000,
    parameter int BOOT_WAIT_CYCLES = 8000000,
    parameter int FIFO_AW          = 4
) (
    input  logic            i_clock,
    input  logic            i_res_n,
    input  logic            i_start,
`ifdef PROPPLUG_LOOPBACK_EN
    input  logic            i_loopback,
`endif
    prop_plug_host_if.slave bus,
    output logic            o_busy,
    output logic            o_target_res,
    output logic            o_txd,
    input  logic            i_rxd
);
    localparam int SEQ_MAX = (RESET_CYCLES > BOOT_WAIT_CYCLES) ? RESET_CYCLES : BOOT_WAIT_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam logic [SEQ_W-1:0] RESET_LOAD = SEQ_W'(RESET_CYCLES - 1);
    localparam logic [SEQ_W-1:0] BOOT_LOAD  = SEQ_W'(BOOT_WAIT_CYCLES - 1);
    localparam logic [15:0]      BAUD_LOAD  = 16'(BAUD_DIV - 1);
    localparam logic [15:0]      HALF_LOAD  = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET_PULSE, S_BOOT_WAIT, S_RUN} seq_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_WAIT_HIGH} rx_state_t;

    seq_state_t       r_seq_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic             r_target_res;

    always_ff @(posedge i_clock or negedge i_res_n) begin
        if (!i_res_n) begin
            r_seq_state  <= S_IDLE;
            r_seq_cnt    <= '0;
            r_target_res <= 1'b0;
        end else if (i_start) begin
            r_seq_state  <= S_RESET_PULSE;
            r_seq_cnt    <= RESET_LOAD;
            r_target_res <= 1'b1;
        end else begin
            case (r_seq_state)
                S_RESET_PULSE: begin
                    if (r_seq_cnt == '0) begin
                        r_seq_state  <= S_BOOT_WAIT;
                        r_seq_cnt    <= BOOT_LOAD;
                        r_target_res <= 1'b0;
                    end else begin
                        r_seq_cnt <= r_seq_cnt - 1'b1;
                    end
                end
                S_BOOT_WAIT: begin
                    if (r_seq_cnt == '0) begin
                        r_seq_state <= S_RUN;
                    end else begin
                        r_seq_cnt <= r_seq_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0]       r_fifo [2**FIFO_AW];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_tx_active;
    logic [7:0]       r_tx_sr;
    logic [3:0]       r_tx_bit;
    logic [15:0]      r_tx_baud;
    logic             r_txd;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                          (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign bus.tx_ready = (r_seq_state == S_RUN) && !w_full;
    assign w_push       = bus.tx_valid && bus.tx_ready && !i_start;
    assign w_pop        = !r_tx_active && !w_empty && !i_start;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= bus.tx_data;
        end
    end

    // The shifter releases itself one cycle before the stop bit ends so the next
    // pop lands exactly on the following bit boundary (no gap between frames).
    always_ff @(posedge i_clock or negedge i_res_n) begin
        if (!i_res_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tx_active <= 1'b0;
            r_tx_sr     <= '0;
            r_tx_bit    <= '0;
            r_tx_baud   <= '0;
            r_txd       <= 1'b1;
        end else if (i_start) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tx_active <= 1'b0;
            r_tx_bit    <= '0;
            r_tx_baud   <= '0;
            r_txd       <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_tx_sr     <= r_fifo[r_rd_ptr[FIFO_AW-1:0]];
                r_tx_bit    <= '0;
                r_tx_baud   <= BAUD_LOAD;
                r_tx_active <= 1'b1;
                r_txd       <= 1'b0;
            end else if (r_tx_active) begin
                if (r_tx_bit == 4'd9 && r_tx_baud == 16'd1) begin
                    r_tx_active <= 1'b0;
                end else if (r_tx_baud != 16'd0) begin
                    r_tx_baud <= r_tx_baud - 16'd1;
                end else begin
                    r_txd     <= r_tx_sr[0];
                    r_tx_sr   <= {1'b1, r_tx_sr[7:1]};
                    r_tx_bit  <= r_tx_bit + 4'd1;
                    r_tx_baud <= BAUD_LOAD;
                end
            end
        end
    end

    assign o_txd        = r_txd;
    assign o_target_res = r_target_res;
    assign o_busy       = (r_seq_state == S_RESET_PULSE) || (r_seq_state == S_BOOT_WAIT) ||
                          !w_empty || r_tx_active;

    logic w_rx_in;
`ifdef PROPPLUG_LOOPBACK_EN
    assign w_rx_in = i_loopback ? r_txd : i_rxd;
`else
    assign w_rx_in = i_rxd;
`endif

    rx_state_t   r_rx_state;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_prev;
    logic [15:0] r_rx_baud;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_sr;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_err;

    // Synchroniser resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge i_clock or negedge i_res_n) begin
        if (!i_res_n) begin
            r_rx_state <= R_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_s1    <= w_rx_in;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= R_START;
                        r_rx_baud  <= HALF_LOAD;
                    end
                end
                R_START: begin
                    if (r_rx_baud != 16'd0) begin
                        r_rx_baud <= r_rx_baud - 16'd1;
                    end else if (r_rx_s2) begin
                        r_rx_state <= R_IDLE;
                    end else begin
                        r_rx_state <= R_DATA;
                        r_rx_baud  <= BAUD_LOAD;
                        r_rx_bit   <= '0;
                    end
                end
                R_DATA: begin
                    if (r_rx_baud != 16'd0) begin
                        r_rx_baud <= r_rx_baud - 16'd1;
                    end else if (r_rx_bit == 4'd8) begin
                        r_rx_data <= r_rx_sr;
                        if (r_rx_s2) begin
                            r_rx_valid <= 1'b1;
                            r_rx_state <= R_IDLE;
                        end else begin
                            r_rx_err   <= 1'b1;
                            r_rx_state <= R_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_sr   <= {r_rx_s2, r_rx_sr[7:1]};
                        r_rx_bit  <= r_rx_bit + 4'd1;
                        r_rx_baud <= BAUD_LOAD;
                    end
                end
                default: begin
                    if (r_rx_s2) begin
                        r_rx_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_err   = r_rx_err;
endmodule

// File: tb/tb_prop_plug_host.sv
// tb/tb_prop_plug_host.sv - Self-checking bench for prop_plug_host against a UART frame model
module tb_prop_plug_host;
    localparam int BAUD  = 8;
    localparam int RST   = 4;
    localparam int BOOT  = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * BAUD;
    localparam int MAXC  = 16384;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic start = 1'b0;
    logic rxd = 1'b1;
    logic busy;
    logic target_res;
    logic txd;
`ifdef PROPPLUG_LOOPBACK_EN
    logic loopback = 1'b0;
`endif

    prop_plug_host_if bus();

    prop_plug_host #(
        .BAUD_DIV(BAUD), .RESET_CYCLES(RST), .BOOT_WAIT_CYCLES(BOOT), .FIFO_AW(AW)
    ) dut (
        .i_clock(clk),
        .i_res_n(res_n),
        .i_start(start),
`ifdef PROPPLUG_LOOPBACK_EN
        .i_loopback(loopback),
`endif
        .bus(bus),
        .o_busy(busy),
        .o_target_res(target_res),
        .o_txd(txd),
        .i_rxd(rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic txd_at [MAXC];
    logic [7:0] rx_q [$];
    int rx_valid_cnt = 0;
    int rx_err_cnt = 0;
    logic [7:0] push_q [$];
    logic [7:0] dec_b [$];
    int dec_s [$];
    int dec_bad;
    int stall_at;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) txd_at[cyc] = txd;
        if (bus.rx_valid === 1'b1) begin
            rx_q.push_back(bus.rx_data);
            rx_valid_cnt++;
        end
        if (bus.rx_err === 1'b1) rx_err_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic measure_seq(input string tag);
        int n;
        bit ok;
        ok = 1'b1;
        n = 0;
        while (target_res === 1'b1 && n < 1000) begin
            if (busy !== 1'b1) ok = 1'b0;
            n++;
            step(1);
        end
        check({tag, "_reset_len"}, n, RST);
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 1000) begin
            if (busy !== 1'b1 || target_res !== 1'b0) ok = 1'b0;
            n++;
            step(1);
        end
        check({tag, "_boot_len"}, n, BOOT);
        check({tag, "_busy_during"}, 32'(ok), 32'd1);
    endtask

    // Pushes push_q with the valid/ready handshake; tx_ready is stable between edges.
    task automatic push_all(input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        stall_at = -1;
        while (i < push_q.size() && guard < 5000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.tx_valid = 1'b0;
                step(1);
            end else begin
                bus.tx_valid = 1'b1;
                bus.tx_data = push_q[i];
                if (bus.tx_ready === 1'b1) begin
                    step(1);
                    i++;
                end else begin
                    if (stall_at < 0) stall_at = i;
                    step(1);
                end
            end
            guard++;
        end
        bus.tx_valid = 1'b0;
        check("push_complete", i, push_q.size());
    endtask

    // Decodes 8N1 frames from the recorded txd trace, sampling each bit at mid-point.
    task automatic decode_tx(input int c0, input int c1);
        int c;
        logic [7:0] b;
        dec_b.delete();
        dec_s.delete();
        dec_bad = 0;
        c = (c0 < 1) ? 1 : c0;
        while (c < c1) begin
            if (txd_at[c-1] === 1'b1 && txd_at[c] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = txd_at[c + BAUD * (k + 1) + BAUD / 2];
                if (txd_at[c + 9 * BAUD + BAUD / 2] !== 1'b1) dec_bad++;
                dec_b.push_back(b);
                dec_s.push_back(c);
                c += FRAME;
            end else begin
                c++;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        step(BAUD);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            step(BAUD);
        end
        rxd = stop_bit;
        step(BAUD);
        rxd = 1'b1;
        step(2 * BAUD);
    endtask

    initial begin
        int n0;
        int mism;
        int nb;
        int lows;
        logic [9:0] fbits;
        logic [7:0] rb;
        logic [7:0] rnd [$];

        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        step(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_target_res", 32'(target_res), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_err", 32'(bus.rx_err), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        res_n = 1'b1;
        step(2);
        check("idle_tx_ready", 32'(bus.tx_ready), 32'd0);

        pulse_start();
        measure_seq("boot");
        check("run_idle_busy", 32'(busy), 32'd0);

        // Single frame 0xA5: compare every cycle of the 80-cycle waveform.
        n0 = cyc;
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hA5;
        step(1);
        bus.tx_valid = 1'b0;
        step(FRAME + 20);
        fbits = {1'b1, 8'hA5, 1'b0};
        mism = 0;
        for (int j = 0; j < FRAME; j++) if (txd_at[n0 + 2 + j] !== fbits[j / BAUD]) mism++;
        check("a5_no_early_fall", 32'(txd_at[n0 + 1]), 32'd1);
        check("a5_wave_mismatches", mism, 0);
        check("a5_idle_after", 32'(txd_at[n0 + 2 + FRAME]), 32'd1);

        // Back-to-back 0x01..0x05: DEPTH bytes queue behind the one already in the shifter.
        push_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        n0 = cyc;
        push_all(1'b0);
        check("burst_no_stall", stall_at, -1);
        check("burst_ready_low_when_full", 32'(bus.tx_ready), 32'd0);
        step(5 * FRAME + 20);
        decode_tx(n0, cyc - FRAME);
        check("burst_frames", dec_b.size(), DEPTH + 1);
        mism = 0;
        for (int i = 0; i < dec_b.size() && i < 5; i++) begin
            if (dec_b[i] !== 8'(i + 1)) mism++;
            if (i > 0 && dec_s[i] - dec_s[i-1] != FRAME) mism++;
        end
        check("burst_order_and_contiguity", mism + dec_bad, 0);

        // Randomized bursts with random valid gaps.
        for (int r = 0; r < 2; r++) begin
            nb = $urandom_range(3, 8);
            push_q.delete();
            for (int i = 0; i < nb; i++) push_q.push_back(8'($urandom));
            n0 = cyc;
            push_all(1'b1);
            step(nb * FRAME + 40);
            decode_tx(n0, cyc - FRAME);
            check("rand_tx_count", dec_b.size(), nb);
            mism = dec_bad;
            for (int i = 0; i < dec_b.size() && i < nb; i++) if (dec_b[i] !== push_q[i]) mism++;
            check("rand_tx_bytes", mism, 0);
            check("rand_tx_drained_busy", 32'(busy), 32'd0);
        end

        // RX: good frame, stop-bit error, glitch, random frames.
        rx_q.delete();
        rx_valid_cnt = 0;
        rx_err_cnt = 0;
        send_rx(8'h3C, 1'b1);
        check("rx_3c_valid_cycles", rx_valid_cnt, 1);
        check("rx_3c_err", rx_err_cnt, 0);
        check("rx_3c_data", 32'(bus.rx_data), 32'h3C);

        rb = 8'($urandom);
        rx_valid_cnt = 0;
        send_rx(rb, 1'b0);
        check("rx_stop0_err", rx_err_cnt, 1);
        check("rx_stop0_no_valid", rx_valid_cnt, 0);
        check("rx_stop0_data", 32'(bus.rx_data), 32'(rb));

        rx_err_cnt = 0;
        rxd = 1'b0;
        step(3);
        rxd = 1'b1;
        step(3 * BAUD);
        check("rx_glitch_strobes", rx_valid_cnt + rx_err_cnt, 0);

        rx_q.delete();
        rnd.delete();
        for (int i = 0; i < 4; i++) begin
            rnd.push_back(8'($urandom));
            send_rx(rnd[i], 1'b1);
        end
        check("rx_rand_count", rx_q.size(), 4);
        mism = 0;
        for (int i = 0; i < rx_q.size() && i < 4; i++) if (rx_q[i] !== rnd[i]) mism++;
        check("rx_rand_bytes", mism, 0);

        // Restart mid-frame with two bytes still queued.
        push_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        push_all(1'b0);
        nb = 0;
        while (txd !== 1'b0 && nb < 100) begin
            nb++;
            step(1);
        end
        check("restart_frame_started", 32'(txd), 32'd0);
        step(4 * BAUD + 3);
        pulse_start();
        n0 = cyc;
        check("restart_txd_high", 32'(txd), 32'd1);
        measure_seq("restart");
        check("restart_fifo_empty_busy", 32'(busy), 32'd0);
        step(3 * FRAME);
        lows = 0;
        for (int c = n0; c < cyc; c++) if (txd_at[c] !== 1'b1) lows++;
        check("restart_no_residual", lows, 0);

`ifdef PROPPLUG_LOOPBACK_EN
        rx_q.delete();
        rx_valid_cnt = 0;
        rx_err_cnt = 0;
        loopback = 1'b1;
        rxd = 1'b0;
        push_q = '{8'h5A};
        push_all(1'b0);
        step(FRAME + 40);
        check("loop_valid", rx_valid_cnt, 1);
        check("loop_data", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF, 32'h5A);
        check("loop_no_err", rx_err_cnt, 0);
        rxd = 1'b1;
        step(2);
        loopback = 1'b0;
        step(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prop_plug_host.md
Name: prop_plug_host

Overview:
- Host-side (Prop Plug) end of the Propeller serial boot/debug link. It can run in FPGA logic instead of the FTDI bridge.
- Pulses the target's reset, waits out the boot delay, then exchanges 8N1 UART bytes:
  - `txd` drives target P31 (RX).
  - `rxd` comes from target P30 (TX).
- Sits in the board top level next to the core's pin mux; a bench or a loader engine drives the byte interface.

Parameters:
- BAUD_DIV, 694, clock cycles per bit (80 MHz / 115200); legal range 4..65535.
- RESET_CYCLES, 8000, cycles `target_res` is held high per `start`.
- BOOT_WAIT_CYCLES, 8000000, cycles from reset release until the TX path is enabled.
- FIFO_AW, 4, TX FIFO address width; depth = 2^FIFO_AW.

Ports:
- clock, in, 1, single clock for all logic.
- res_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; begins a target reset sequence.
- tx_data, in, 8, byte to send.
- tx_valid, in, 1, tx_data valid.
- tx_ready, out, 1, FIFO can accept a byte.
- rx_data, out, 8, last received byte.
- rx_valid, out, 1, one-cycle strobe; rx_data is new.
- rx_err, out, 1, one-cycle strobe; stop bit was sampled low.
- busy, out, 1, sequencer not in RUN, or FIFO non-empty, or shifter active.
- target_res, out, 1, active-high reset to the target Propeller.
- txd, out, 1, serial out, idles high.
- rxd, in, 1, serial in, asynchronous.

Behaviour:
- Reset (res_n low), asynchronous:
  - Sequencer goes to IDLE; FIFO is emptied; shifters are cleared.
  - Outputs: txd=1, target_res=0, tx_ready=0, rx_valid=0, rx_err=0, rx_data=0, busy=0.
- Sequencer states: IDLE -> RESET_PULSE -> BOOT_WAIT -> RUN.
  - IDLE: waits for `start`. tx_ready=0. RX path is active.
  - RESET_PULSE: target_res=1 for exactly RESET_CYCLES cycles. The FIFO and TX shifter are flushed on entry. txd=1.
  - BOOT_WAIT: target_res=0. Counts BOOT_WAIT_CYCLES, then goes to RUN.
  - RUN: tx_ready = !fifo_full. Stays in RUN until the next `start`.
  - `start` in any state restarts RESET_PULSE on the next cycle:
    - the counter reloads;
    - a frame being transmitted is aborted and txd returns high immediately.
- TX handshake:
  - A byte is accepted when tx_valid && tx_ready.
  - tx_valid while tx_ready=0 is ignored; it does not stall or corrupt state.
  - Full FIFO: tx_ready=0 in the same cycle the last slot fills.
  - Empty FIFO: the shifter idles with txd=1.
  - FIFO pointers are FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1).
- TX framing, per byte:
  - Bit order: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts BAUD_DIV cycles.
  - The shifter pops a byte the cycle after it goes idle. Back-to-back frames leave no idle gap beyond the stop bit.
  - Latency: txd falls 2 cycles after acceptance into an empty FIFO when the shifter is idle.
- RX:
  - `rxd` passes through a 2-flop synchroniser.
  - A start is detected on a synchronised 1->0 edge while the receiver is idle.
  - The start bit is re-checked at BAUD_DIV/2 (integer division). If it reads high, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled every BAUD_DIV cycles after that point. The stop bit is sampled one BAUD_DIV later.
  - Stop=1: rx_data updates and rx_valid pulses 1 cycle.
  - Stop=0: rx_data updates and rx_err pulses instead of rx_valid. The receiver then waits for rxd=1 before re-arming.
  - No RX buffering: a consumer that misses the strobe loses the byte.
  - RX runs in every sequencer state and is not reset by `start`.
- Counters saturate/reload only as stated; no other wrap is permitted.

Optional Feature:
- Macro: PROPPLUG_LOOPBACK_EN.
- Defined:
  - Adds input port `loopback` (1 bit).
  - When loopback=1, the RX synchroniser input is internal txd instead of `rxd`.
  - Pin txd still toggles normally.
- Undefined: no `loopback` port; RX always uses `rxd`.

Test Plan (BAUD_DIV=8, RESET_CYCLES=4, BOOT_WAIT_CYCLES=16, FIFO_AW=2):
- Reset: deassert res_n, pulse start -> target_res high exactly 4 cycles; tx_ready rises 16 cycles after target_res falls; busy=1 throughout.
- TX frame: push 0xA5 in RUN -> txd falls 2 cycles later, then bits 1,0,1,0,0,1,0,1, then stop 1, each held 8 cycles; 80 cycles per frame total.
- FIFO full and back-to-back: push 5 bytes 0x01..0x05 in consecutive cycles with tx_valid held -> tx_ready drops when the FIFO holds 4 (0x05 is accepted only after the first pop); all 5 frames are contiguous, in order.
- RX: drive rxd with a 0x3C frame -> rx_valid 1 cycle with rx_data=0x3C. Stop bit forced 0 -> rx_err pulses, rx_valid stays 0. A 3-cycle low glitch -> no strobe.
- Mid-operation restart: pulse start during bit 4 of a TX frame with 2 bytes queued -> txd=1 next cycle, FIFO empty, target_res high 4 cycles, no residual frames.
- Loopback (macro defined): loopback=1, push 0x5A -> rx_valid with rx_data=0x5A; rxd held at 0 causes no rx_err.
